// File: rtl/status_led_pkg.sv
// -----------------------------------------------------------------------------
// status_led_pkg
//   Shared types and constants for the status LED driver.
//   led_mode_t  : per-channel LED behaviour. Codes 5..7 are not enumerated and
//                 behave like LED_OFF.
//   LED_MODE_W  : width of one channel's mode field in the packed mode bus.
// -----------------------------------------------------------------------------
package status_led_pkg;

  localparam int LED_MODE_W = 3;

  typedef enum logic [LED_MODE_W-1:0] {
    LED_OFF     = 3'd0,
    LED_ON      = 3'd1,
    LED_BREATHE = 3'd2,
    LED_BLINK   = 3'd3,
    LED_ACTIVE  = 3'd4
  } led_mode_t;

endpackage

// File: rtl/status_led_if.sv
// -----------------------------------------------------------------------------
// status_led_if
//   Signal bundle between the LED driver and its user.
//   mode        : per-channel mode, channel i = mode[LED_MODE_W*i +: LED_MODE_W]
//   act_pulse   : per-channel activity strobe (single cycle or level)
//   stretch_len : hold time in cycles after the last strobe, shared by channels
//   led         : registered LED drive
//   act_busy    : per-channel "hold counter nonzero" flag
//   master modport drives mode/act_pulse/stretch_len, slave drives led/act_busy.
// -----------------------------------------------------------------------------
interface status_led_if
  import status_led_pkg::*;
#(
  parameter int NCH       = 3,
  parameter int STRETCH_W = 22
);

  logic [LED_MODE_W*NCH-1:0] mode;
  logic [NCH-1:0]            act_pulse;
  logic [STRETCH_W-1:0]      stretch_len;
  logic [NCH-1:0]            led;
  logic [NCH-1:0]            act_busy;

  modport master (
    output mode,
    output act_pulse,
    output stretch_len,
    input  led,
    input  act_busy
  );

  modport slave (
    input  mode,
    input  act_pulse,
    input  stretch_len,
    output led,
    output act_busy
  );

endinterface

// File: rtl/led_stretch.sv
// -----------------------------------------------------------------------------
// led_stretch
//   One activity hold counter. A strobe loads len_i; otherwise the counter
//   decrements to zero and stops. A strobe always wins, so a retrigger on the
//   last hold cycle extends the hold rather than letting it lapse.
//   clk_sys  : system clock
//   reset_n  : synchronous active-low reset, aborts any running hold
//   pulse_i  : activity strobe
//   len_i    : reload value
//   busy_o   : registered "counter nonzero" flag
// -----------------------------------------------------------------------------
module led_stretch #(
  parameter int STRETCH_W = 22
) (
  input  logic                 clk_sys,
  input  logic                 reset_n,
  input  logic                 pulse_i,
  input  logic [STRETCH_W-1:0] len_i,
  output logic                 busy_o
);

  logic [STRETCH_W-1:0] h_q, h_d;
  logic                 busy_q, busy_d;

  always_comb begin
    h_d = '0;
    if (pulse_i) begin
      h_d = len_i;
    end else if (h_q != '0) begin
      h_d = h_q - STRETCH_W'(1);
    end
    busy_d = (h_d != '0);
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      h_q    <= '0;
      busy_q <= 1'b0;
    end else begin
      h_q    <= h_d;
      busy_q <= busy_d;
    end
  end

  // busy_q always equals (h_q != 0); registering it keeps the output a flop.
  assign busy_o = busy_q;

endmodule

// File: rtl/status_led_ctrl.sv
// -----------------------------------------------------------------------------
// status_led_ctrl
//   Multi-channel status LED driver. A shared free-running phase counter feeds
//   breathe and blink patterns; each channel selects off, on, breathe, blink or
//   activity-stretch and drives one registered LED output.
//   clk_sys : system clock
//   reset_n : synchronous active-low reset
//   bus     : status_led_if slave (mode, act_pulse, stretch_len in;
//             led, act_busy out)
//   Parameters: NCH channels, CNT_W phase counter bits (breathe period
//   2^CNT_W), PWM_W breathe resolution (PWM_W <= CNT_W-2), STRETCH_W hold
//   counter bits, ACT_LOW inverts every led output.
// -----------------------------------------------------------------------------
module status_led_ctrl
  import status_led_pkg::*;
#(
  parameter int NCH       = 3,
  parameter int CNT_W     = 27,
  parameter int PWM_W     = 8,
  parameter int STRETCH_W = 22,
  parameter bit ACT_LOW   = 1'b0
) (
  input  logic         clk_sys,
  input  logic         reset_n,
  status_led_if.slave  bus
);

  if (PWM_W > CNT_W - 2) begin : g_bad_cfg
    $error("status_led_ctrl: PWM_W must not exceed CNT_W-2");
  end

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NCH-1:0]   led_q, led_d;
  logic [NCH-1:0]   val;
  logic [NCH-1:0]   busy;

  // Shared pattern terms. duty ramps once per half period; lo is the fast
  // sawtooth it is compared against. In the first half the LED is lit while
  // duty <= lo, in the second half while duty > lo, so brightness sweeps one
  // way and then mirrors back.
  logic [PWM_W-1:0] duty, lo;
  logic             ph;
  logic             breathe_v;
  logic             blink_v;

  assign cnt_d     = cnt_q + CNT_W'(1);
  assign duty      = cnt_q[CNT_W-2 -: PWM_W];
  assign lo        = cnt_q[PWM_W-1:0];
  assign ph        = cnt_q[CNT_W-1];
  assign breathe_v = ph ? (duty > lo) : (duty <= lo);
  assign blink_v   = cnt_q[CNT_W-2];

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    led_mode_t mode_ch;
    logic      val_ch;

    assign mode_ch = led_mode_t'(bus.mode[LED_MODE_W*i +: LED_MODE_W]);

    led_stretch #(
      .STRETCH_W (STRETCH_W)
    ) u_stretch (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .pulse_i (bus.act_pulse[i]),
      .len_i   (bus.stretch_len),
      .busy_o  (busy[i])
    );

    // In ACTIVE the strobe itself lights the LED on the next edge, and the
    // current hold keeps it lit; this gives stretch_len cycles of afterglow
    // after the strobe cycle, and a plain one-cycle echo when stretch_len=0.
    always_comb begin
      val_ch = 1'b0;
      case (mode_ch)
        LED_OFF:     val_ch = 1'b0;
        LED_ON:      val_ch = 1'b1;
        LED_BREATHE: val_ch = breathe_v;
        LED_BLINK:   val_ch = blink_v;
        LED_ACTIVE:  val_ch = busy[i] | bus.act_pulse[i];
        default:     val_ch = 1'b0;
      endcase
    end

    assign val[i] = val_ch;
  end

  assign led_d = val ^ {NCH{ACT_LOW}};

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      cnt_q <= '0;
      led_q <= {NCH{ACT_LOW}};
    end else begin
      cnt_q <= cnt_d;
      led_q <= led_d;
    end
  end

  assign bus.led      = led_q;
  assign bus.act_busy = busy;

endmodule

// File: tb/tb_status_led_ctrl.sv
module tb_status_led_ctrl;
  import status_led_pkg::*;

  localparam int NCH   = 3;
  localparam int CNT_W = 10;
  localparam int PWM_W = 4;
  localparam int SW    = 4;

  localparam int PERIOD   = 2 ** CNT_W;           // 1024
  localparam int HALF     = 2 ** (CNT_W - 1);     // 512
  localparam int DSTEP    = 2 ** (CNT_W - 1 - PWM_W); // 32 cycles per duty step
  localparam int NLO      = 2 ** PWM_W;           // 16
  localparam int BLINK_HP = 2 ** (CNT_W - 2);     // 256

  logic clk_sys = 1'b0;
  logic reset_n;
  always #5 clk_sys = ~clk_sys;

  status_led_if #(.NCH(NCH), .STRETCH_W(SW)) bus0 ();
  status_led_if #(.NCH(NCH), .STRETCH_W(SW)) bus1 ();

  assign bus1.mode        = bus0.mode;
  assign bus1.act_pulse   = bus0.act_pulse;
  assign bus1.stretch_len = bus0.stretch_len;

  status_led_ctrl #(
    .NCH(NCH), .CNT_W(CNT_W), .PWM_W(PWM_W), .STRETCH_W(SW), .ACT_LOW(1'b0)
  ) dut0 (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .bus     (bus0)
  );

  status_led_ctrl #(
    .NCH(NCH), .CNT_W(CNT_W), .PWM_W(PWM_W), .STRETCH_W(SW), .ACT_LOW(1'b1)
  ) dut1 (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .bus     (bus1)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: phase as an integer, holds as "time of last strobe
  // plus its length".
  int             m_cnt = 0;
  int             c_used = 0;
  int             edge_n = 0;
  int             last_p [NCH];
  int             last_l [NCH];
  logic [NCH-1:0] exp_led = '0;
  logic [NCH-1:0] exp_busy = '0;
  int             hc [2*NLO];

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [NCH-1:0] nled, nbusy;
    int md, duty, lo;
    logic p, v;
    nled  = '0;
    nbusy = '0;
    if (!reset_n) begin
      m_cnt = 0;
      for (int i = 0; i < NCH; i++) begin
        last_p[i] = 0;
        last_l[i] = 0;
      end
    end else begin
      c_used = m_cnt;
      for (int i = 0; i < NCH; i++) begin
        md = int'(bus0.mode[3*i +: 3]);
        p  = bus0.act_pulse[i];
        v  = 1'b0;
        case (md)
          1: v = 1'b1;
          2: begin
            duty = (c_used / DSTEP) % NLO;
            lo   = c_used % NLO;
            v    = (c_used >= HALF) ? (duty > lo) : (duty <= lo);
          end
          3: v = ((c_used / BLINK_HP) % 2) == 1;
          4: v = p | exp_busy[i];
          default: v = 1'b0;
        endcase
        nled[i] = v;
        if (p) begin
          last_p[i] = edge_n;
          last_l[i] = int'(bus0.stretch_len);
        end
        nbusy[i] = (edge_n - last_p[i]) < last_l[i];
      end
      m_cnt = (c_used + 1) % PERIOD;
    end
    exp_led  = nled;
    exp_busy = nbusy;
    edge_n++;
  endtask

  task automatic tick();
    logic [NCH-1:0] inv;
    @(posedge clk_sys);
    model_step();
    @(negedge clk_sys);
    inv = ~exp_led;
    check("led", bus0.led, exp_led);
    check("act_busy", bus0.act_busy, exp_busy);
    check("led_actlow", bus1.led, inv);
    check("act_busy_actlow", bus1.act_busy, exp_busy);
  endtask

  task automatic set_mode(int ch, logic [2:0] m);
    bus0.mode[3*ch +: 3] = m;
  endtask

  task automatic run_seq(string nm, int ch, int n, logic [15:0] pat,
                         logic [15:0] eled, logic [15:0] ebusy);
    for (int k = 0; k < n; k++) begin
      bus0.act_pulse[ch] = pat[k];
      tick();
      check($sformatf("%s led k=%0d", nm, k), bus0.led[ch], eled[k]);
      check($sformatf("%s busy k=%0d", nm, k), bus0.act_busy[ch], ebusy[k]);
    end
    bus0.act_pulse[ch] = 1'b0;
  endtask

  initial begin
    int viol;
    reset_n          = 1'b0;
    bus0.mode        = '0;
    bus0.act_pulse   = '0;
    bus0.stretch_len = '0;

    // 1: reset held for 3 cycles
    for (int k = 0; k < 3; k++) begin
      tick();
      check("reset led", bus0.led, 0);
      check("reset busy", bus0.act_busy, 0);
      check("reset led_actlow", bus1.led, 3'b111);
    end

    // Release; blink on ch0 pins the phase counter start at 0
    reset_n = 1'b1;
    set_mode(0, LED_BLINK);
    set_mode(2, LED_BREATHE);
    for (int k = 1; k <= 256; k++) tick();
    check("blink before cnt=256", bus0.led[0], 0);
    tick();
    check("blink at cnt=256", bus0.led[0], 1);

    // 2: breathe on ch0 for two full periods
    set_mode(0, LED_BREATHE);
    set_mode(2, LED_BLINK);
    tick();
    for (int b = 0; b < 2*NLO; b++) hc[b] = 0;
    for (int k = 0; k < 2048; k++) begin
      tick();
      hc[c_used / DSTEP] += int'(bus0.led[0]);
    end
    check("breathe hc[0]", hc[0], 64);
    check("breathe hc[15]", hc[15], 4);
    check("breathe hc[16]", hc[16], 0);
    check("breathe hc[31]", hc[31], 60);
    viol = 0;
    for (int d = 0; d < NLO - 1; d++) begin
      if (hc[d+1] >= hc[d]) viol++;
      if (hc[NLO+d+1] <= hc[NLO+d]) viol++;
    end
    for (int d = 0; d < NLO; d++)
      if (hc[d] + hc[NLO+d] != 64) viol++;
    check("breathe monotonic/mirror", viol, 0);

    // 3/4: activity stretch on ch1
    set_mode(0, LED_OFF);
    set_mode(2, LED_OFF);
    set_mode(1, LED_ACTIVE);
    bus0.stretch_len = 4'd5;
    for (int k = 0; k < 4; k++) tick();
    run_seq("single", 1, 8, 16'h0001, 16'h003F, 16'h001F);
    for (int k = 0; k < 4; k++) tick();
    run_seq("double", 1, 12, 16'h0011, 16'h03FF, 16'h01FF);
    for (int k = 0; k < 4; k++) tick();
    run_seq("retrig h1", 1, 13, 16'h0021, 16'h07FF, 16'h03FF);
    for (int k = 0; k < 4; k++) tick();

    // Mode change mid-hold, then stretch_len change affecting only next reload
    bus0.act_pulse[1] = 1'b1;
    tick();
    bus0.act_pulse[1] = 1'b0;
    set_mode(1, LED_ON);
    bus0.stretch_len = 4'd2;
    tick();
    set_mode(1, LED_ACTIVE);
    for (int k = 0; k < 8; k++) tick();

    // 5: stretch_len = 0 on ch2
    bus0.stretch_len = 4'd0;
    set_mode(1, LED_OFF);
    set_mode(2, LED_ACTIVE);
    run_seq("zero len", 2, 7, 16'h000D, 16'h000D, 16'h0000);

    // 6: active-low drive and reset mid-hold
    set_mode(0, LED_ON);
    set_mode(1, LED_OFF);
    set_mode(2, 3'd7);
    tick();
    check("actlow pattern", bus1.led, 3'b110);
    check("actlow pattern high", bus0.led, 3'b001);
    bus0.stretch_len = 4'd5;
    bus0.act_pulse[1] = 1'b1;
    tick();
    bus0.act_pulse[1] = 1'b0;
    tick();
    check("hold in OFF mode", bus1.act_busy, 3'b010);
    reset_n = 1'b0;
    tick();
    check("mid-hold reset led", bus1.led, 3'b111);
    check("mid-hold reset busy", bus1.act_busy, 3'b000);
    reset_n = 1'b1;
    set_mode(1, LED_ACTIVE);
    tick();
    check("hold aborted", bus0.act_busy, 3'b000);
    for (int k = 0; k < 4; k++) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
